piece_bag_generator: RTL

Produces the stream of Tetris pieces consumed as `new_piece` by `game_executioner`, replacing the SPI-driven piece select. It implements a 7-bag randomizer: every aligned group of 7 dealt pieces is a permutation of all 7 tetrominoes. Draws use a free-running Galois LFSR. A small preview queue exposes upcoming pieces for `game_decoder` telemetry and next-piece display. Runs in the `game_clk` domain alongside the executioner.

---
 rtl/tetris_pkg.sv | 51 +++++
 rtl/lfsr_galois.sv | 26 ++
 rtl/piece_bag_generator.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris types: piece encoding, bag-generator constants and decode helpers.
package tetris_pkg;

    localparam int PIECE_INDEX_WIDTH = 3;
    localparam int NUM_PIECES        = 7;

    // Feedback mask for x^16+x^14+x^13+x^11+1 in a right-shifting Galois LFSR.
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;

    typedef logic [PIECE_INDEX_WIDTH-1:0] piece_index_t;

    typedef enum logic [2:0] {
        HERO           = 3'd0,
        SMASH_BOY      = 3'd1,
        TEEWEE         = 3'd2,
        ORANGE_RICKY   = 3'd3,
        BLUE_RICKY     = 3'd4,
        RHODE_ISLAND_Z = 3'd5,
        CLEVELAND_Z    = 3'd6
    } active_piece_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_READY = 1'b1
    } bag_state_t;

    // Decode a bag index into the piece type used by the executioner.
    function automatic active_piece_t index_to_piece(piece_index_t idx);
        case (idx)
            3'd0:    return HERO;
            3'd1:    return SMASH_BOY;
            3'd2:    return TEEWEE;
            3'd3:    return ORANGE_RICKY;
            3'd4:    return BLUE_RICKY;
            3'd5:    return RHODE_ISLAND_Z;
            3'd6:    return CLEVELAND_Z;
            default: return HERO;
        endcase
    endfunction

    // Number of set bits in a 7-piece used mask.
    function automatic logic [2:0] count_ones7(logic [NUM_PIECES-1:0] mask);
        logic [2:0] total;
        total = '0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            total = total + {2'b00, mask[i]};
        end
        return total;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Free-running right-shifting Galois LFSR with a soft seed load; zero seeds fall back to SEED.
module lfsr_galois #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value
);

    // Advance every cycle; a load or reset replaces the state (never with all-zeros).
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            value <= SEED;
        end else if (load) begin
            value <= (load_value == '0) ? SEED : load_value;
        end else begin
            value <= (value >> 1) ^ (value[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/piece_bag_generator.sv
// 7-bag piece generator: LFSR-seeded draws without replacement feeding a small preview queue.
module piece_bag_generator
    import tetris_pkg::*;
#(
    parameter int                    LFSR_WIDTH    = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED          = 16'hACE1,
    parameter int                    PREVIEW_DEPTH = 3
) (
    input  logic                           game_clk,
    input  logic                           reset_n,
    input  logic                           seed_load,
    input  logic [LFSR_WIDTH-1:0]          seed_value,
    input  logic                           piece_request,
    output logic                           piece_valid,
    output logic [2:0]                     piece_index,
    output active_piece_t                  new_piece,
    output logic [PREVIEW_DEPTH-1:0][2:0]  preview_index,
    output logic [2:0]                     bag_remaining,
    output logic [7:0]                     pieces_dealt
);

    localparam int QUEUE_DEPTH = PREVIEW_DEPTH + 1;
    // Count value at which the current fill draw completes the queue.
    localparam logic [2:0] LAST_FILL = 3'(PREVIEW_DEPTH);
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = LFSR_WIDTH'(LFSR_TAPS_16);

    logic [LFSR_WIDTH-1:0]   lfsr_value;
    bag_state_t              state, next_state;
    logic                    do_fill, do_pop;
    logic [NUM_PIECES-1:0]   used, used_after;
    logic [2:0]              count;
    logic                    valid_q;
    logic [7:0]              dealt;
    piece_index_t            queue_q [QUEUE_DEPTH];

    piece_index_t            draw_start, draw_index, scan_slot;
    logic [3:0]              scan_sum;
    logic                    draw_found;

    lfsr_galois #(
        .WIDTH (LFSR_WIDTH),
        .TAPS  (LFSR_TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk        (game_clk),
        .reset_n    (reset_n),
        .load       (seed_load),
        .load_value (seed_value),
        .value      (lfsr_value)
    );

    // First-free scan from the LFSR start point; the seventh draw of a bag clears the mask.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        draw_start = (lfsr_value[2:0] == 3'd7) ? 3'd0 : lfsr_value[2:0];
        draw_index = draw_start;
        draw_found = 1'b0;
        scan_sum   = '0;
        scan_slot  = '0;
        for (int k = 0; k < NUM_PIECES; k++) begin
            scan_sum  = {1'b0, draw_start} + 4'(k);
            scan_slot = (scan_sum >= 4'd7) ? 3'(scan_sum - 4'd7) : scan_sum[2:0];
            if (!draw_found && !used[scan_slot]) begin
                draw_index = scan_slot;
                draw_found = 1'b1;
            end
        end
        used_after = used | (7'b1 << draw_index);
        if (used_after == 7'h7F) begin
            used_after = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            state <= ST_FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath strobes; a seed load overrides any fill or pop.
    always_comb begin
        next_state = state;
        do_fill    = 1'b0;
        do_pop     = 1'b0;
        case (state)
            ST_FILL: begin
                do_fill = 1'b1;
                if (count == LAST_FILL) begin
                    next_state = ST_READY;
                end
            end
            ST_READY: begin
                do_pop = piece_request;
            end
            default: next_state = ST_FILL;
        endcase
        if (seed_load) begin
            next_state = ST_FILL;
            do_fill    = 1'b0;
            do_pop     = 1'b0;
        end
    end

    // Used mask, queue, fill count, valid flag and dealt counter.
    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            // NOTE: the queue is a handful of flops, not a RAM, and its zero state is visible on outputs, so it is reset.
            used    <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            dealt   <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else if (seed_load) begin
            used    <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= '0;
            end
        end else begin
            if (do_fill || do_pop) begin
                used <= used_after;
            end
            if (do_fill) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (count == 3'(i)) begin
                        queue_q[i] <= draw_index;
                    end
                end
                count <= count + 3'd1;
            end
            if (do_pop) begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) begin
                    queue_q[i] <= queue_q[i+1];
                end
                queue_q[QUEUE_DEPTH-1] <= draw_index;
                dealt <= dealt + 8'd1;
            end
            valid_q <= (next_state == ST_READY);
        end
    end

    // Output decodes of the registered state.
    always_comb begin
        piece_valid   = valid_q;
        piece_index   = queue_q[0];
        new_piece     = index_to_piece(queue_q[0]);
        bag_remaining = 3'(NUM_PIECES) - count_ones7(used);
        pieces_dealt  = dealt;
        preview_index = '0;
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            preview_index[i] = queue_q[i+1];
        end
    end

endmodule
